uart_rx: RTL and testbench

- UART receiver: 8N1 asynchronous serial in, byte stream out.
- Sits between the board-level uart_rx pin of risc_v and the memory-mapped UART register block.
- Counterpart of the core's transmitter; also instantiated standalone in benches as a monitor on uart_tx.
- Oversamples with a clock-divider counter and presents received bytes on a valid/ready handshake through a one-entry holding register.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync_ff.sv | 24 ++
 rtl/uart_rx.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The parity option is selected per build with UART_RX_PARITY_EN.
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

  // Value the parity bit must carry so the nine bits hold an even number of ones.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync_ff.sv
// Multi-stage synchronizer for asynchronous single-bit inputs.
// It resets to 1 so that an idle-high line reads as idle from the first cycle.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 serial in, one-entry holding register with valid/ready out.
// Define UART_RX_PARITY_EN to expect an even-parity bit and add the parity_err port.
//
// Handshake: rx_data is held stable while rx_valid=1; a byte moves when
// rx_valid && rx_ready at a rising edge. rx_valid then drops unless a new byte
// lands in the same edge.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun,
`ifdef UART_RX_PARITY_EN
  output logic                      parity_err,
`endif
  output logic                      busy,
  output uart_rx_state_t            state_dbg
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  localparam uart_rx_state_t AFTER_DATA = PARITY;
`else
  localparam uart_rx_state_t AFTER_DATA = STOP;
`endif

  logic                      rx_s;
  uart_rx_state_t            state_q;
  logic [CNT_W-1:0]          clk_cnt_q;
  logic [2:0]                bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] rx_data_q;
  logic                      rx_valid_q;
  logic                      frame_err_q;
  logic                      overrun_q;
  logic                      half_tick_d;
  logic                      bit_tick_d;
  logic                      accept_room_d;
`ifdef UART_RX_PARITY_EN
  logic                      parity_bit_q;
  logic                      parity_err_q;
`endif

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  assign half_tick_d   = (clk_cnt_q == HALF_M1);
  assign bit_tick_d    = (clk_cnt_q == FULL_M1);
  // The holding register can take a byte if empty or being drained this cycle.
  assign accept_room_d = !rx_valid_q || rx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          if (!rx_s) begin
            state_q <= START;
          end
        end

        START: begin
          if (half_tick_d) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (bit_tick_d) begin
            clk_cnt_q <= '0;
            shift_q   <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
            if (bit_idx_q == 3'd7) begin
              state_q <= AFTER_DATA;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_tick_d) begin
            clk_cnt_q    <= '0;
            parity_bit_q <= rx_s;
            state_q      <= STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
`endif

        STOP: begin
          if (bit_tick_d) begin
            clk_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= (even_parity(shift_q) != parity_bit_q);
`endif
            if (rx_s) begin
              state_q <= IDLE;
              if (accept_room_d) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        BREAK: begin
          clk_cnt_q <= '0;
          if (rx_s) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q   <= IDLE;
          clk_cnt_q <= '0;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at CLKS_PER_BIT=8: directed frames plus random bytes,
// with an expected-byte queue and pulse counters; honours UART_RX_PARITY_EN.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB  = 8;
  localparam int SYNC = 2;

  logic                      clk;
  logic                      rst;
  logic                      rx;
  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ready;
  logic                      frame_err;
  logic                      overrun;
  logic                      busy;
  uart_rx_state_t            state_dbg;
`ifdef UART_RX_PARITY_EN
  logic                      parity_err;
`endif

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [UART_DATA_BITS-1:0] exp_q[$];
  int vec_cnt    = 0;
  int miss_cnt   = 0;
  int acc_cnt    = 0;
  int fe_cnt     = 0;
  int ov_cnt     = 0;
  int pe_cnt     = 0;
  int val_cycles = 0;
  bit busy_seen  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every accepted byte must be the oldest byte the model expects.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_seen = 1'b1;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) pe_cnt++;
`endif
      if (rx_valid) val_cycles++;
      if (rx_valid && rx_ready) begin
        acc_cnt++;
        chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  // Full frame, LSB first; parity bit only exists in parity builds.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_b);
`else
    if (par_b) begin end
`endif
    send_bit(stop_b);
    rx = 1'b1;
  endtask

  // A good frame the model says will be delivered.
  task automatic send_good(input logic [7:0] d);
    exp_q.push_back(d);
    send_frame(d, 1'b1, ^d);
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_rx_data"},   32'(rx_data),   32'd0);
    chk({tag, "_rx_valid"},  32'(rx_valid),  32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_overrun"},   32'(overrun),   32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    tick(1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int acc0, fe0, ov0, pe0, val0;
    logic [7:0] b;

    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b1;
    tick(3);
    check_idle_outputs("reset");
    rst = 1'b0;
    tick(2 * CPB);

    // 0x55 clean frame: one byte, one valid cycle, no error pulses.
    acc0 = acc_cnt; fe0 = fe_cnt; ov0 = ov_cnt; val0 = val_cycles;
    send_good(8'h55);
    tick(2 * CPB);
    chk("h55_accepted",  32'(acc_cnt - acc0),    32'd1);
    chk("h55_valid_cyc", 32'(val_cycles - val0), 32'd1);
    chk("h55_frame_err", 32'(fe_cnt - fe0),      32'd0);
    chk("h55_overrun",   32'(ov_cnt - ov0),      32'd0);

    // Short low glitch: busy blips, then nothing is reported.
    acc0 = acc_cnt; fe0 = fe_cnt;
    busy_seen = 1'b0;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(3 * CPB);
    chk("glitch_busy_seen", 32'(busy_seen),       32'd1);
    chk("glitch_busy_end",  32'(busy),            32'd0);
    chk("glitch_no_byte",   32'(acc_cnt - acc0),  32'd0);
    chk("glitch_no_fe",     32'(fe_cnt - fe0),    32'd0);

    // 0xA3 with a low stop bit then a held-low line: exactly one frame_err.
    acc0 = acc_cnt; fe0 = fe_cnt;
    send_frame(8'hA3, 1'b0, ^8'hA3);
    rx = 1'b0;
    tick(40);
    chk("brk_one_fe",    32'(fe_cnt - fe0),   32'd1);
    chk("brk_no_byte",   32'(acc_cnt - acc0), 32'd0);
    chk("brk_busy_held", 32'(busy),           32'd1);
    rx = 1'b1;
    tick(2 * CPB);
    chk("brk_released", 32'(busy), 32'd0);
    acc0 = acc_cnt;
    send_good(8'h0F);
    tick(2 * CPB);
    chk("brk_h0f_accepted", 32'(acc_cnt - acc0), 32'd1);
    chk("brk_fe_total",     32'(fe_cnt - fe0),   32'd1);

    // Consumer stalled: 0x11 held, 0x22 dropped with one overrun pulse.
    acc0 = acc_cnt; ov0 = ov_cnt;
    rx_ready = 1'b0;
    send_good(8'h11);
    tick(CPB);
    send_frame(8'h22, 1'b1, ^8'h22);
    tick(2 * CPB);
    @(negedge clk);
    chk("ovr_data_held",  32'(rx_data),       32'h11);
    chk("ovr_valid_held", 32'(rx_valid),      32'd1);
    chk("ovr_one_pulse",  32'(ov_cnt - ov0),  32'd1);
    tick(1);
    rx_ready = 1'b1;
    tick(3);
    chk("ovr_drained",    32'(rx_valid),      32'd0);
    chk("ovr_accepted",   32'(acc_cnt - acc0), 32'd1);

    // Reset in the middle of 0x7E's data bits aborts it; 0xC4 follows cleanly.
    acc0 = acc_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    b = 8'h7E;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(b[i]);
    rst = 1'b1;
    rx = 1'b1;
    tick(2);
    check_idle_outputs("midrst");
    rst = 1'b0;
    tick(3 * CPB);
    chk("midrst_no_byte", 32'(acc_cnt - acc0), 32'd0);
    send_good(8'hC4);
    tick(2 * CPB);
    chk("midrst_hc4",     32'(acc_cnt - acc0), 32'd1);
    chk("midrst_no_fe",   32'(fe_cnt - fe0),   32'd0);
    chk("midrst_no_ov",   32'(ov_cnt - ov0),   32'd0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so the even-parity bit must be 1.
    acc0 = acc_cnt; pe0 = pe_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    tick(2 * CPB);
    chk("par_bad_pulse", 32'(pe_cnt - pe0),   32'd1);
    chk("par_bad_byte",  32'(acc_cnt - acc0), 32'd1);
    pe0 = pe_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    tick(2 * CPB);
    chk("par_good_none", 32'(pe_cnt - pe0),   32'd0);
`endif

    // Random bytes with random idle gaps, including back-to-back frames.
    acc0 = acc_cnt; fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom_range(0, 255));
      send_good(b);
      tick($urandom_range(0, 2) * CPB + $urandom_range(0, CPB - 1));
    end
    tick(3 * CPB);
    chk("rnd_accepted", 32'(acc_cnt - acc0), 32'd24);
    chk("rnd_no_fe",    32'(fe_cnt - fe0),   32'd0);
    chk("rnd_no_ov",    32'(ov_cnt - ov0),   32'd0);
    chk("rnd_no_pe",    32'(pe_cnt - pe0),   32'd0);
    chk("queue_empty",  32'(exp_q.size()),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
